// File: rtl/adder_pkg.sv
`default_nettype none
// ============================================================================
// Package     : adder_pkg
// Description : Tree-shape and width helpers shared by the adder family.
// Revision    : 1.0
// ============================================================================
package adder_pkg;

    // Depth of a pairwise reduction tree over n operands (ceil(log2(n))).
    function automatic int tree_levels(input int n);
        int levels;
        int span;
        levels = 0;
        span   = 1;
        while (span < n) begin
            span   = span * 2;
            levels = levels + 1;
        end
        return levels;
    endfunction

    // Number of operands present after k pairwise levels (level 0 = inputs).
    function automatic int level_count(input int n, input int k);
        int cnt;
        cnt = n;
        for (int i = 0; i < k; i++) begin
            cnt = (cnt + 1) / 2;
        end
        return cnt;
    endfunction

    function automatic int tree_out_width(input int in_width, input int n);
        return in_width + tree_levels(n);
    endfunction

    function automatic int tree_latency(input int n);
        return 1 + tree_levels(n);
    endfunction

endpackage : adder_pkg
`default_nettype wire

// File: rtl/adder_tree_level.sv
`default_nettype none
// ============================================================================
// Module      : adder_tree_level
// Description : One registered pairwise add level; an odd leftover passes through.
// Revision    : 1.0
// ============================================================================
module adder_tree_level #(
    parameter int N_IN = 2,
    parameter int W    = 8
) (
    input  logic                        clk,
    input  logic                        resetn,
    input  logic                        en,
    input  logic [N_IN*W-1:0]           in_data,
    output logic [((N_IN+1)/2)*W-1:0]   out_data
);

    localparam int N_OUT = (N_IN + 1) / 2;

    logic [N_OUT*W-1:0] w_sum;
    logic [N_OUT*W-1:0] r_sum;

    for (genvar j = 0; j < N_OUT; j++) begin : g_pair
        if (2*j + 1 < N_IN) begin : g_add
            assign w_sum[j*W +: W] = in_data[(2*j)*W +: W] + in_data[(2*j+1)*W +: W];
        end else begin : g_pass
            assign w_sum[j*W +: W] = in_data[(2*j)*W +: W];
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_sum <= '0;
        end else if (en) begin
            r_sum <= w_sum;
        end
    end

    assign out_data = r_sum;

endmodule : adder_tree_level
`default_nettype wire

// File: rtl/adder_tree_nto1_pipe.sv
`default_nettype none
// ============================================================================
// Module      : adder_tree_nto1_pipe
// Description : Pipelined N:1 signed add/subtract tree with valid/ready flow.
// Revision    : 1.0
// ============================================================================
module adder_tree_nto1_pipe
    import adder_pkg::*;
#(
    parameter  int NUM_IN    = 5,
    parameter  int IN_WIDTH  = 251,
    localparam int LEVELS    = tree_levels(NUM_IN),
    localparam int OUT_WIDTH = tree_out_width(IN_WIDTH, NUM_IN),
    localparam int LAT       = tree_latency(NUM_IN)
) (
    input  logic                        clk,
    input  logic                        resetn,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [NUM_IN*IN_WIDTH-1:0]  in_data,
    input  logic [NUM_IN-1:0]           sub_mask,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [OUT_WIDTH-1:0]        out_data
);

    logic                           w_advance;
    logic [LAT-1:0]                 r_valid;
    logic [NUM_IN*OUT_WIDTH-1:0]    w_stage0;
    logic [NUM_IN*OUT_WIDTH-1:0]    r_stage0;

    assign w_advance = ~out_valid | out_ready;
    assign in_ready  = w_advance;
    assign out_valid = r_valid[LAT-1];

    // The extra LEVELS bits make the negation of the most negative operand exact.
    for (genvar i = 0; i < NUM_IN; i++) begin : g_op
        logic [IN_WIDTH-1:0]  w_op;
        logic [OUT_WIDTH-1:0] w_ext;
        assign w_op  = in_data[i*IN_WIDTH +: IN_WIDTH];
        assign w_ext = {{LEVELS{w_op[IN_WIDTH-1]}}, w_op};
        assign w_stage0[i*OUT_WIDTH +: OUT_WIDTH] = sub_mask[i] ? (~w_ext + 1'b1) : w_ext;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_stage0 <= '0;
            r_valid  <= '0;
        end else if (w_advance) begin
            r_stage0 <= w_stage0;
            r_valid  <= {r_valid[LAT-2:0], in_valid};
        end
    end

    for (genvar k = 1; k <= LEVELS; k++) begin : g_lvl
        localparam int N_K_IN  = level_count(NUM_IN, k-1);
        localparam int N_K_OUT = level_count(NUM_IN, k);

        logic [N_K_IN*OUT_WIDTH-1:0]  w_in;
        logic [N_K_OUT*OUT_WIDTH-1:0] w_out;

        if (k == 1) begin : g_first
            assign w_in = r_stage0;
        end else begin : g_chain
            assign w_in = g_lvl[k-1].w_out;
        end

        adder_tree_level #(
            .N_IN (N_K_IN),
            .W    (OUT_WIDTH)
        ) u_level (
            .clk      (clk),
            .resetn   (resetn),
            .en       (w_advance),
            .in_data  (w_in),
            .out_data (w_out)
        );
    end

    assign out_data = g_lvl[LEVELS].w_out;

endmodule : adder_tree_nto1_pipe
`default_nettype wire

// File: tb/tb_adder_tree_nto1_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_adder_tree_nto1_pipe
// Description : Directed self-checking bench for adder_tree_nto1_pipe (5 x 8-bit).
// Revision    : 1.0
// ============================================================================
module tb_adder_tree_nto1_pipe;

    localparam int NUM_IN = 5;
    localparam int IN_W   = 8;
    localparam int OUT_W  = 11;
    localparam int LAT    = 4;

    logic                    clk;
    logic                    resetn;
    logic                    in_valid;
    logic                    in_ready;
    logic [NUM_IN*IN_W-1:0]  in_data;
    logic [NUM_IN-1:0]       sub_mask;
    logic                    out_valid;
    logic                    out_ready;
    logic [OUT_W-1:0]        out_data;

    int n_total = 0;
    int n_pass  = 0;
    int cyc     = 0;
    logic [OUT_W-1:0] sb_q[$];
    int               res_cyc[$];

    adder_tree_nto1_pipe #(
        .NUM_IN   (NUM_IN),
        .IN_WIDTH (IN_W)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .sub_mask  (sub_mask),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [OUT_W-1:0] model(input logic [NUM_IN*IN_W-1:0] d,
                                               input logic [NUM_IN-1:0] m);
        logic [OUT_W-1:0] acc;
        logic [OUT_W-1:0] x;
        acc = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            x = {{(OUT_W-IN_W){d[i*IN_W+IN_W-1]}}, d[i*IN_W +: IN_W]};
            acc = m[i] ? acc - x : acc + x;
        end
        return acc;
    endfunction

    function automatic logic [NUM_IN*IN_W-1:0] pack5(input logic [7:0] a0, input logic [7:0] a1,
                                                     input logic [7:0] a2, input logic [7:0] a3,
                                                     input logic [7:0] a4);
        return {a4, a3, a2, a1, a0};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One clock: record accepts/deliveries just before the edge, return at edge+1.
    task automatic tick();
        logic [OUT_W-1:0] exp;
        #1;
        if (in_valid && in_ready) sb_q.push_back(model(in_data, sub_mask));
        if (out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                check("spurious_out", {31'd0, out_valid}, 32'd0);
            end else begin
                exp = sb_q.pop_front();
                check("result", {21'd0, out_data}, {21'd0, exp});
                res_cyc.push_back(cyc);
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_one(input string tag, input logic [NUM_IN*IN_W-1:0] d,
                           input logic [NUM_IN-1:0] m, input logic [OUT_W-1:0] hand_exp);
        int lat;
        out_ready = 1'b1;
        in_data   = d;
        sub_mask  = m;
        in_valid  = 1'b1;
        tick();
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 12) begin
            tick();
            lat++;
        end
        check({tag, "_latency"}, lat, LAT);
        check({tag, "_data"}, {21'd0, out_data}, {21'd0, hand_exp});
        tick();
    endtask

    initial begin
        logic [OUT_W-1:0] held;
        int guard;

        resetn    = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        sub_mask  = '0;
        out_ready = 1'b1;
        #3;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_data",  {21'd0, out_data},  32'd0);
        check("rst_in_ready",  {31'd0, in_ready},  32'd1);
        @(posedge clk);
        #1;
        resetn = 1'b1;

        // Max positive sum, then exact negation of the most negative operand.
        run_one("t1_pos_max", pack5(8'd127, 8'd127, 8'd127, 8'd127, 8'd127), 5'b00000, 11'h27B);
        run_one("t2_neg_sub", pack5(8'h80, 8'h80, 8'h80, 8'h80, 8'h80), 5'b11111, 11'h280);
        run_one("t2_neg_add", pack5(8'h80, 8'h80, 8'h80, 8'h80, 8'h80), 5'b00000, 11'h580);
        // Odd fifth operand must stay aligned through the passthrough registers.
        run_one("t3_odd",     pack5(8'd1, 8'd2, 8'd3, 8'd4, 8'd100), 5'b10000, 11'h7A6);

        // Streaming at full throughput.
        res_cyc.delete();
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            in_data  = {$urandom(), $urandom()};
            sub_mask = 5'($urandom());
            in_valid = 1'b1;
            check("t4_in_ready", {31'd0, in_ready}, 32'd1);
            tick();
        end
        in_valid = 1'b0;
        guard = 0;
        while (sb_q.size() != 0 && guard < 20) begin
            tick();
            guard++;
        end
        check("t4_count", res_cyc.size(), 20);
        if (res_cyc.size() == 20) check("t4_back_to_back", res_cyc[19] - res_cyc[0], 19);

        // Back-pressure: fill, stall 6 cycles, release.
        res_cyc.delete();
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_data  = {$urandom(), $urandom()};
            sub_mask = 5'($urandom());
            in_valid = 1'b1;
            tick();
        end
        in_data  = {$urandom(), $urandom()};
        sub_mask = 5'($urandom());
        held     = out_data;
        for (int i = 0; i < 6; i++) begin
            #1;
            check("t5_in_ready",  {31'd0, in_ready},  32'd0);
            check("t5_out_valid", {31'd0, out_valid}, 32'd1);
            check("t5_stable",    {21'd0, out_data},  {21'd0, held});
            if (sb_q.size() != 0) check("t5_head", {21'd0, out_data}, {21'd0, sb_q[0]});
            tick();
        end
        out_ready = 1'b1;
        tick();
        in_data  = {$urandom(), $urandom()};
        sub_mask = 5'($urandom());
        tick();
        in_valid = 1'b0;
        guard = 0;
        while (sb_q.size() != 0 && guard < 20) begin
            tick();
            guard++;
        end
        check("t5_count", res_cyc.size(), 6);
        if (res_cyc.size() == 6) check("t5_no_gap", res_cyc[5] - res_cyc[0], 5);

        // Reset with sets in flight.
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_data  = {$urandom(), $urandom()};
            sub_mask = 5'($urandom());
            in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        check("t6_pre_valid", {31'd0, out_valid}, 32'd1);
        #2;
        resetn = 1'b0;
        #1;
        check("t6_rst_valid", {31'd0, out_valid}, 32'd0);
        check("t6_rst_data",  {21'd0, out_data},  32'd0);
        sb_q.delete();
        res_cyc.delete();
        @(posedge clk);
        @(posedge clk);
        #3;
        resetn = 1'b1;
        @(posedge clk);
        #1;
        run_one("t6_post_a", pack5(8'd10, 8'hF6, 8'd7, 8'd0, 8'd3), 5'b00100, 11'h7FC);
        run_one("t6_post_b", pack5(8'd5, 8'd5, 8'd5, 8'd5, 8'd5), 5'b01010, 11'h005);
        for (int i = 0; i < 8; i++) tick();
        check("t6_count", res_cyc.size(), 2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_adder_tree_nto1_pipe
`default_nettype wire
